// File: rtl/rom_prefetch_queue.sv
// Instruction prefetch queue: walks the combinational program ROM ahead of the CPU
// and buffers {pc, instruction} pairs in a small FIFO drained by a valid/ready handshake.
module rom_prefetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 24,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hf
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [INSTR_W-1:0]       rom_data_i,
    output logic                     ins_valid_o,
    input  logic                     ins_ready_i,
    output logic [INSTR_W-1:0]       ins_data_o,
    output logic [ADDR_W-1:0]        ins_pc_o,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_addr_i,
    output logic                     fetch_halted_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d;
    logic [ADDR_W-1:0]  pcMem_q   [DEPTH];
    logic [INSTR_W-1:0] dataMem_q [DEPTH];
    logic               push, pop;

    // Redirect outranks everything: it flushes the queue and blocks both push and pop.
    always_comb begin
        pop       = ins_valid_o & ins_ready_i & ~redirect_i;
        push      = ~redirect_i & ~halted_q & ((count_q != CNT_W'(DEPTH)) | pop);
        fetchPc_d = fetchPc_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        halted_d  = halted_q;
        if (redirect_i) begin
            fetchPc_d = redirect_addr_i;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            halted_d  = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d   = wrPtr_q + PTR_W'(1);
                fetchPc_d = fetchPc_q + ADDR_W'(1);
                if (rom_data_i[INSTR_W-1 -: 4] == HALT_OP) begin
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetchPc_q <= RESET_PC;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
        end else begin
            fetchPc_q <= fetchPc_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]   <= '0;
                dataMem_q[i] <= '0;
            end
        end else if (push) begin
            pcMem_q[wrPtr_q]   <= fetchPc_q;
            dataMem_q[wrPtr_q] <= rom_data_i;
        end
    end

    assign rom_addr_o     = fetchPc_q;
    assign ins_valid_o    = (count_q != '0);
    assign ins_data_o     = dataMem_q[rdPtr_q];
    assign ins_pc_o       = pcMem_q[rdPtr_q];
    assign fetch_halted_o = halted_q;
    assign count_o        = count_q;

endmodule

// File: tb/tb_rom_prefetch_queue.sv
// Self-checking bench for rom_prefetch_queue: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_rom_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  romAddr;
    logic [23:0] romData;
    logic        insValid;
    logic        insReady = 1'b0;
    logic [23:0] insData;
    logic [7:0]  insPc;
    logic        redirect = 1'b0;
    logic [7:0]  redirectAddr = '0;
    logic        fetchHalted;
    logic [2:0]  count;

    logic [23:0] rom [256];

    int errors = 0;
    int checks = 0;

    logic [31:0] mQueue [$];
    logic [7:0]  mPc;
    logic        mHalted;

    typedef struct {
        logic       ready;
        logic       redir;
        logic [7:0] raddr;
        logic       expValid;
        logic [7:0] expPc;
        logic [2:0] expCount;
        logic [7:0] expAddr;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    assign romData = rom[romAddr];

    rom_prefetch_queue dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rom_addr_o      (romAddr),
        .rom_data_i      (romData),
        .ins_valid_o     (insValid),
        .ins_ready_i     (insReady),
        .ins_data_o      (insData),
        .ins_pc_o        (insPc),
        .redirect_i      (redirect),
        .redirect_addr_i (redirectAddr),
        .fetch_halted_o  (fetchHalted),
        .count_o         (count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of {pc, word} pairs with the documented push/pop rules.
    task automatic modelEdge(input logic rdy, input logic rd, input logic [7:0] ra);
        logic popped;
        logic pushed;
        if (rd) begin
            mQueue.delete();
            mPc     = ra;
            mHalted = 1'b0;
        end else begin
            popped = (mQueue.size() != 0) && rdy;
            pushed = !mHalted && ((mQueue.size() < 4) || popped);
            if (popped) void'(mQueue.pop_front());
            if (pushed) begin
                mQueue.push_back({mPc, rom[mPc]});
                if (rom[mPc][23:20] == 4'hf) mHalted = 1'b1;
                mPc = mPc + 8'd1;
            end
        end
    endtask

    task automatic compareModel(input string tag);
        logic [31:0] head;
        checkOutput({tag, ".valid"}, 32'(insValid), 32'(mQueue.size() != 0));
        checkOutput({tag, ".count"}, 32'(count), 32'(mQueue.size()));
        checkOutput({tag, ".romAddr"}, 32'(romAddr), 32'(mPc));
        checkOutput({tag, ".halted"}, 32'(fetchHalted), 32'(mHalted));
        if (mQueue.size() != 0) begin
            head = mQueue[0];
            checkOutput({tag, ".pc"}, 32'(insPc), 32'(head[31:24]));
            checkOutput({tag, ".data"}, 32'(insData), 32'(head[23:0]));
        end
    endtask

    // Drives one cycle of inputs, advances the model on the edge, then samples 1ns later.
    task automatic applyStimulus(input logic rdy, input logic rd, input logic [7:0] ra, input string tag);
        insReady     = rdy;
        redirect     = rd;
        redirectAddr = ra;
        @(posedge clk);
        modelEdge(rdy, rd, ra);
        #1;
        compareModel(tag);
    endtask

    // Asserts reset between edges and checks that outputs clear without waiting for a clock.
    task automatic doReset(input string tag);
        insReady     = 1'b0;
        redirect     = 1'b0;
        redirectAddr = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput({tag, ".rstValid"}, 32'(insValid), 32'd0);
        checkOutput({tag, ".rstCount"}, 32'(count), 32'd0);
        checkOutput({tag, ".rstAddr"}, 32'(romAddr), 32'd0);
        checkOutput({tag, ".rstData"}, 32'(insData), 32'd0);
        checkOutput({tag, ".rstPc"}, 32'(insPc), 32'd0);
        checkOutput({tag, ".rstHalted"}, 32'(fetchHalted), 32'd0);
        mQueue.delete();
        mPc     = 8'd0;
        mHalted = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'h100000 + 24'(i);

        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd1, 8'h01};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 8'h02};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 8'h03};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 8'h04};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 8'h04};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 8'h04};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 8'h04};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 8'h04};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 3'd4, 8'h05};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 3'd4, 8'h06};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 3'd4, 8'h06};
        vecs[11] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0, 8'h40};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd1, 8'h41};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 3'd1, 8'h42};

        // Vector table: fill to full, full-plus-pop, redirect while full.
        doReset("tbl");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].ready, vecs[i].redir, vecs[i].raddr, $sformatf("tbl%0d", i));
            checkOutput($sformatf("tbl%0d.expValid", i), 32'(insValid), 32'(vecs[i].expValid));
            checkOutput($sformatf("tbl%0d.expCount", i), 32'(count), 32'(vecs[i].expCount));
            checkOutput($sformatf("tbl%0d.expAddr", i), 32'(romAddr), 32'(vecs[i].expAddr));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("tbl%0d.expPc", i), 32'(insPc), 32'(vecs[i].expPc));
                checkOutput($sformatf("tbl%0d.expData", i), 32'(insData), 32'h100000 + 32'(vecs[i].expPc));
            end
        end

        // Streaming with ready held high: one instruction per cycle, no gaps.
        doReset("stream");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, $sformatf("stream%0d", k));
            checkOutput($sformatf("stream%0d.pc", k), 32'(insPc), 32'(k));
            checkOutput($sformatf("stream%0d.valid", k), 32'(insValid), 32'd1);
        end

        // Redirect with three entries queued and ready high: nothing stale reaches the CPU.
        doReset("redir3");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 8'h00, "redir3.fill");
        checkOutput("redir3.count3", 32'(count), 32'd3);
        applyStimulus(1'b1, 1'b1, 8'h40, "redir3.flush");
        checkOutput("redir3.flushValid", 32'(insValid), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, "redir3.first");
        checkOutput("redir3.firstPc", 32'(insPc), 32'h40);

        // HALT at pc3 stops fetch; queue drains; redirect resumes.
        rom[3] = 24'hF00000;
        doReset("halt");
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 8'h00, "halt.fill");
        checkOutput("halt.halted", 32'(fetchHalted), 32'd1);
        checkOutput("halt.addrHold", 32'(romAddr), 32'd4);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 8'h00, "halt.drain");
        checkOutput("halt.drained", 32'(insValid), 32'd0);
        checkOutput("halt.stillAddr", 32'(romAddr), 32'd4);
        applyStimulus(1'b0, 1'b1, 8'h00, "halt.redir");
        checkOutput("halt.resumeFlag", 32'(fetchHalted), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, "halt.restart");
        checkOutput("halt.restartPc", 32'(insPc), 32'd0);
        rom[3] = 24'h100003;

        // Address wrap at the top of the ROM, then an asynchronous reset mid-stream.
        applyStimulus(1'b1, 1'b1, 8'hFE, "wrap.redir");
        applyStimulus(1'b1, 1'b0, 8'h00, "wrap0");
        checkOutput("wrap0.pc", 32'(insPc), 32'hFE);
        applyStimulus(1'b1, 1'b0, 8'h00, "wrap1");
        checkOutput("wrap1.pc", 32'(insPc), 32'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00, "wrap2");
        checkOutput("wrap2.pc", 32'(insPc), 32'h00);
        doReset("midRst");
        applyStimulus(1'b1, 1'b0, 8'h00, "midRst.restart");
        checkOutput("midRst.restartPc", 32'(insPc), 32'd0);

        // Randomized traffic with random ROM contents (occasional HALT opcodes).
        for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
        doReset("rand");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'(($urandom % 4) != 0), 1'(($urandom % 20) == 0),
                          8'($urandom), $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
